ctrl_pipe_regs: RTL and testbench
=================================

Name: ctrl_pipe_regs

Overview:
- Carries decoded control fields from the Decode stage of the 5-stage pipeline through Execute, Memory and Writeback.
- Sits directly downstream of the decode-stage control unit and consumes its D-stage outputs.
- Resolves branch/jump redirection in Execute (PCSrcE) from ALU flags.
- Keeps a retired-instruction counter in Writeback.

Parameters:
- ALUCTRL_W, 3, width of the ALU control field.
- RSRC_W, 2, width of the result-source select.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ValidD  in  1  instruction in D is real (0 after FlushD or at startup).
- ResultSrcD  in  RSRC_W  result select: 00 ALU, 01 memory, 10 PC+4.
- MemWriteD  in  1  store enable.
- ALUSrcD  in  1  ALU B-operand select: 1 = immediate.
- RegWriteD  in  1  register-file write enable.
- ALUControlD  in  ALUCTRL_W  ALU operation.
- JumpD  in  1  jal/jalr.
- BranchD  in  1  conditional branch.
- funct3D  in  3  branch condition selector.
- FlushE  in  1  from hazard unit; insert bubble into E.
- ZeroE  in  1  ALU result == 0.
- LtE  in  1  signed A < B.
- LtuE  in  1  unsigned A < B.
- ALUControlE  out  ALUCTRL_W  to ALU.
- ALUSrcE  out  1  to operand mux.
- ResultSrcE0  out  1  ResultSrcE[0], used for load-use hazard detection.
- RegWriteE  out  1  to hazard unit.
- PCSrcE  out  1  redirect fetch to branch/jump target.
- MemWriteM  out  1  data-memory write enable.
- RegWriteM  out  1  forwarding qualifier.
- ResultSrcW  out  RSRC_W  writeback mux select.
- RegWriteW  out  1  register-file write enable.
- RetiredW  out  CNT_W  count of valid instructions reaching W.

Behaviour:
- Reset (reset=0, asynchronous): all E/M/W registers and RetiredW clear to 0. All outputs are 0, including PCSrcE. Registers stay 0 for as long as reset is held.
- D→E register on each rising edge:
  - FlushE=1: load an all-zero bubble (ValidE=0, all enables 0, ALUControlE=0). Flush has priority over capture.
  - FlushE=0: capture all D fields plus ValidD.
  - There is no stall input; E, M and W never stall.
- E→M and M→W registers capture unconditionally each cycle. Carried fields:
  - E→M: ValidE, RegWriteE, MemWriteE, ResultSrcE.
  - M→W: ValidM, RegWriteM, ResultSrcM.
- Every write enable is ANDed with its stage valid on output, so a bubble can never write memory or the register file.
- PCSrcE is combinational: ValidE & (JumpE | (BranchE & takenE)). takenE by funct3E:
  - 000 (beq): ZeroE
  - 001 (bne): !ZeroE
  - 100 (blt): LtE
  - 101 (bge): !LtE
  - 110 (bltu): LtuE
  - 111 (bgeu): !LtuE
  - 010 and 011: 0
- Latency: D fields appear at E outputs 1 cycle later, at M 2 cycles, at W 3 cycles.
- RetiredW increments by 1 on every edge where ValidW=1. Wraps from 2^CNT_W−1 to 0 with no flag.
- Simultaneous FlushE and a taken branch in E: the current E still drives PCSrcE=1 in that cycle; the next E is a bubble.
- Reset mid-operation: in-flight instructions are discarded and the counter clears. After reset deasserts, the first capture occurs on the next rising edge.

Decomposition:
- Shared package (e.g. riscv_pkg): ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4) and branch funct3 constants (F3_BEQ … F3_BGEU).
- Also in the package: a packed struct for the E-stage control bundle, so flushing is a single assignment of '0.
- One sub-module: branch_cond (funct3, Zero, Lt, Ltu → taken), purely combinational, reused by any future branch predictor check.

Test Plan:
- Reset: hold reset=0 while driving RegWriteD=1 and ValidD=1. All outputs stay 0 and RetiredW=0. Release reset: RegWriteW=1 appears 3 edges later.
- Flush: RegWriteD=1, MemWriteD=1, ValidD=1 with FlushE=1 on the same edge. RegWriteE=0, then MemWriteM=0, then RegWriteW=0, and RetiredW does not increment.
- Branch matrix: BranchD=1, sweep all 8 funct3 values × {ZeroE, LtE, LtuE} combinations. PCSrcE matches the table; funct3=010 and 011 always give 0; ValidD=0 always gives 0.
- Jump: JumpD=1, BranchD=0, ZeroE=0. PCSrcE=1 in E. ResultSrcD=10 gives ResultSrcW=10 three cycles later.
- Load-use: ResultSrcD=01, RegWriteD=1. ResultSrcE0=1 and RegWriteE=1 one cycle later; RegWriteM=1 the cycle after.
- Counter: stream 10 valid instructions with 2 flushed between them. RetiredW=10. With CNT_W=4 and 17 valid instructions, RetiredW=1 (wraps).

Source files
------------

// File: rtl/ctrl_pipe_regs_pkg.sv
// Shared encodings and the E-stage control bundle for the D->E->M->W control pipeline.
// Flushing E is a single '0 assignment of ctrl_e_t, which is why all E fields live in one struct.
package ctrl_pipe_regs_pkg;

  localparam int ALUCTRL_WIDTH = 3;
  localparam int RSRC_WIDTH    = 2;

  localparam logic [RSRC_WIDTH-1:0] RES_ALU = 2'b00;
  localparam logic [RSRC_WIDTH-1:0] RES_MEM = 2'b01;
  localparam logic [RSRC_WIDTH-1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic                     valid;
    logic                     regwrite;
    logic                     memwrite;
    logic [RSRC_WIDTH-1:0]    resultsrc;
    logic                     alusrc;
    logic [ALUCTRL_WIDTH-1:0] alucontrol;
    logic                     jump;
    logic                     branch;
    logic [2:0]               funct3;
  } ctrl_e_t;

endpackage

// File: rtl/ctrl_pipe_regs_branch_cond.sv
// Branch condition evaluation from funct3 and ALU flags; purely combinational, no state.
// Reserved funct3 encodings (010, 011) never report taken.
module branch_cond
  import ctrl_pipe_regs_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_regs.sv
// Control pipeline registers D->E->M->W with branch resolution in E and a retired counter in W.
// Latency 1/2/3 cycles to E/M/W outputs; the pipeline never stalls, only FlushE inserts bubbles.
module ctrl_pipe_regs
  import ctrl_pipe_regs_pkg::*;
#(
  parameter int ALUCTRL_W = ALUCTRL_WIDTH,
  parameter int RSRC_W    = RSRC_WIDTH,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ValidD,
  input  logic [RSRC_W-1:0]    ResultSrcD,
  input  logic                 MemWriteD,
  input  logic                 ALUSrcD,
  input  logic                 RegWriteD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic [2:0]           funct3D,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic                 ResultSrcE0,
  output logic                 RegWriteE,
  output logic                 PCSrcE,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic [RSRC_W-1:0]    ResultSrcW,
  output logic                 RegWriteW,
  output logic [CNT_W-1:0]     RetiredW
);

  ctrl_e_t ctrl_d;
  ctrl_e_t ctrl_e;

  logic              valid_m;
  logic              regwrite_m;
  logic              memwrite_m;
  logic [RSRC_W-1:0] resultsrc_m;
  logic              valid_w;
  logic              regwrite_w;
  logic [RSRC_W-1:0] resultsrc_w;
  logic [CNT_W-1:0]  retired_q;
  logic              taken_e;

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.valid      = ValidD;
    ctrl_d.regwrite   = RegWriteD;
    ctrl_d.memwrite   = MemWriteD;
    ctrl_d.resultsrc  = ResultSrcD;
    ctrl_d.alusrc     = ALUSrcD;
    ctrl_d.alucontrol = ALUControlD;
    ctrl_d.jump       = JumpD;
    ctrl_d.branch     = BranchD;
    ctrl_d.funct3     = funct3D;
  end

  // Flush wins over capture so a redirect always kills the wrong-path instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_e <= '0;
    end else if (FlushE) begin
      ctrl_e <= '0;
    end else begin
      ctrl_e <= ctrl_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_m     <= 1'b0;
      regwrite_m  <= 1'b0;
      memwrite_m  <= 1'b0;
      resultsrc_m <= '0;
      valid_w     <= 1'b0;
      regwrite_w  <= 1'b0;
      resultsrc_w <= '0;
    end else begin
      valid_m     <= ctrl_e.valid;
      regwrite_m  <= ctrl_e.regwrite;
      memwrite_m  <= ctrl_e.memwrite;
      resultsrc_m <= ctrl_e.resultsrc;
      valid_w     <= valid_m;
      regwrite_w  <= regwrite_m;
      resultsrc_w <= resultsrc_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (valid_w) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  branch_cond u_branch_cond (
    .funct3 (ctrl_e.funct3),
    .zero   (ZeroE),
    .lt     (LtE),
    .ltu    (LtuE),
    .taken  (taken_e)
  );

  // Enables are gated by stage valid so a bubble can never write state.
  assign ALUControlE = ctrl_e.alucontrol;
  assign ALUSrcE     = ctrl_e.alusrc;
  assign ResultSrcE0 = ctrl_e.resultsrc[0];
  assign RegWriteE   = ctrl_e.regwrite & ctrl_e.valid;
  assign PCSrcE      = ctrl_e.valid & (ctrl_e.jump | (ctrl_e.branch & taken_e));
  assign MemWriteM   = memwrite_m & valid_m;
  assign RegWriteM   = regwrite_m & valid_m;
  assign ResultSrcW  = resultsrc_w;
  assign RegWriteW   = regwrite_w & valid_w;
  assign RetiredW    = retired_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Self-checking bench for ctrl_pipe_regs: W-stage scoreboard plus per-feature inline checks.
module tb_ctrl_pipe_regs;

  logic       clk;
  logic       reset;
  logic       ValidD, MemWriteD, ALUSrcD, RegWriteD, JumpD, BranchD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD, funct3D;
  logic       FlushE, ZeroE, LtE, LtuE;

  logic [2:0]  ALUControlE;
  logic        ALUSrcE, ResultSrcE0, RegWriteE, PCSrcE, MemWriteM, RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] RetiredW;

  logic [2:0]  w4_ALUControlE;
  logic        w4_ALUSrcE, w4_ResultSrcE0, w4_RegWriteE, w4_PCSrcE, w4_MemWriteM, w4_RegWriteM, w4_RegWriteW;
  logic [1:0]  w4_ResultSrcW;
  logic [3:0]  w4_RetiredW;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] resultsrc;
  } w_exp_t;

  w_exp_t      sb_q[$];
  logic [31:0] exp_retired;
  int          checks;
  int          errors;

  ctrl_pipe_regs dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .ALUControlD(ALUControlD), .JumpD(JumpD),
    .BranchD(BranchD), .funct3D(funct3D), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .ResultSrcE0(ResultSrcE0), .RegWriteE(RegWriteE),
    .PCSrcE(PCSrcE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .ResultSrcW(ResultSrcW),
    .RegWriteW(RegWriteW), .RetiredW(RetiredW)
  );

  ctrl_pipe_regs #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ValidD(ValidD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .ALUControlD(ALUControlD), .JumpD(JumpD),
    .BranchD(BranchD), .funct3D(funct3D), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ALUControlE(w4_ALUControlE), .ALUSrcE(w4_ALUSrcE), .ResultSrcE0(w4_ResultSrcE0),
    .RegWriteE(w4_RegWriteE), .PCSrcE(w4_PCSrcE), .MemWriteM(w4_MemWriteM), .RegWriteM(w4_RegWriteM),
    .ResultSrcW(w4_ResultSrcW), .RegWriteW(w4_RegWriteW), .RetiredW(w4_RetiredW)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic taken_ref(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Called between a falling and the next rising edge; pops the W result due now, drives D, pushes.
  task automatic cycle(input logic v, input logic [1:0] rs, input logic mw, input logic as,
                       input logic rw, input logic [2:0] alu, input logic j, input logic b,
                       input logic [2:0] f3, input logic fl);
    w_exp_t e;
    w_exp_t n;
    if (sb_q.size() == 3) begin
      e = sb_q.pop_front();
      checks++;
      if (RegWriteW !== (e.valid & e.regwrite) || ResultSrcW !== e.resultsrc) begin
        errors++;
        $display("FAIL wstage: RegWriteW=%b ResultSrcW=%b required %b %b",
                 RegWriteW, ResultSrcW, e.valid & e.regwrite, e.resultsrc);
      end
      checks++;
      if (RetiredW !== exp_retired) begin
        errors++;
        $display("FAIL retired: RetiredW=%0d required %0d", RetiredW, exp_retired);
      end
      if (e.valid) exp_retired = exp_retired + 1;
    end
    ValidD = v; ResultSrcD = rs; MemWriteD = mw; ALUSrcD = as; RegWriteD = rw;
    ALUControlD = alu; JumpD = j; BranchD = b; funct3D = f3; FlushE = fl;
    n.valid     = v & !fl;
    n.regwrite  = rw & !fl;
    n.resultsrc = fl ? 2'b00 : rs;
    sb_q.push_back(n);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bubble();
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    ValidD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1; BranchD = 1'b0;
    ResultSrcD = 2'b10; ALUControlD = 3'b101; ALUSrcD = 1'b1; funct3D = 3'b000;
    FlushE = 1'b0; ZeroE = 1'b1; LtE = 1'b0; LtuE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ALUControlE, ALUSrcE, ResultSrcE0, RegWriteE, PCSrcE, MemWriteM, RegWriteM,
           ResultSrcW, RegWriteW, RetiredW, w4_RetiredW} !== '0) begin
        errors++;
        $display("FAIL reset_hold: E=%b/%b/%b/%b pc=%b M=%b/%b W=%b/%b cnt=%0d cnt4=%0d required all 0",
                 ALUControlE, ALUSrcE, ResultSrcE0, RegWriteE, PCSrcE, MemWriteM, RegWriteM,
                 ResultSrcW, RegWriteW, RetiredW, w4_RetiredW);
      end
    end
    reset = 1'b1;
    sb_q.delete();
    exp_retired = '0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    checks++;
    if (RegWriteE !== 1'b1) begin
      errors++; $display("FAIL reset_first_e: RegWriteE=%b required 1", RegWriteE);
    end
    bubble();
    bubble();
    checks++;
    if (RegWriteW !== 1'b1) begin
      errors++; $display("FAIL reset_first_w: RegWriteW=%b required 1", RegWriteW);
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 3'b000, 1'b1);
    checks++;
    if (RegWriteE !== 1'b0 || ALUControlE !== 3'b000 || ALUSrcE !== 1'b0) begin
      errors++;
      $display("FAIL flush_e: RegWriteE=%b ALUControlE=%b ALUSrcE=%b required 0 000 0",
               RegWriteE, ALUControlE, ALUSrcE);
    end
    bubble();
    checks++;
    if (MemWriteM !== 1'b0) begin
      errors++; $display("FAIL flush_m: MemWriteM=%b required 0", MemWriteM);
    end
    // Invalid D slot with enables set must be harmless too.
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    checks++;
    if (RegWriteE !== 1'b0) begin
      errors++; $display("FAIL invalid_e: RegWriteE=%b required 0", RegWriteE);
    end
    bubble();
    checks++;
    if (MemWriteM !== 1'b0 || RegWriteM !== 1'b0) begin
      errors++; $display("FAIL invalid_m: MemWriteM=%b RegWriteM=%b required 0 0", MemWriteM, RegWriteM);
    end
    cycle(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    bubble();
    checks++;
    if (MemWriteM !== 1'b1) begin
      errors++; $display("FAIL store_m: MemWriteM=%b required 1", MemWriteM);
    end
  endtask

  task automatic test_branch_matrix();
    logic exp;
    for (int f = 0; f < 8; f++) begin
      for (int v = 0; v < 2; v++) begin
        cycle(v[0], 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, f[2:0], 1'b0);
        for (int fl = 0; fl < 8; fl++) begin
          {ZeroE, LtE, LtuE} = fl[2:0];
          #1;
          exp = v[0] & taken_ref(f[2:0], fl[2], fl[1], fl[0]);
          checks++;
          if (PCSrcE !== exp) begin
            errors++;
            $display("FAIL branch f3=%b valid=%0d zlt=%b: PCSrcE=%b required %b",
                     f[2:0], v, fl[2:0], PCSrcE, exp);
          end
        end
      end
    end
  endtask

  task automatic test_flush_branch();
    cycle(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0);
    ZeroE = 1'b1; LtE = 1'b0; LtuE = 1'b0;
    FlushE = 1'b1;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin
      errors++; $display("FAIL flush_taken_now: PCSrcE=%b required 1", PCSrcE);
    end
    cycle(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b1);
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      errors++; $display("FAIL flush_taken_next: PCSrcE=%b required 0", PCSrcE);
    end
  endtask

  task automatic test_jump();
    cycle(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 3'b010, 1'b0);
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin
      errors++; $display("FAIL jump_pcsrc: PCSrcE=%b required 1", PCSrcE);
    end
    bubble();
    bubble();
    checks++;
    if (ResultSrcW !== 2'b10 || RegWriteW !== 1'b1) begin
      errors++; $display("FAIL jump_w: ResultSrcW=%b RegWriteW=%b required 10 1", ResultSrcW, RegWriteW);
    end
  endtask

  task automatic test_load_use();
    cycle(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0);
    checks++;
    if (ResultSrcE0 !== 1'b1 || RegWriteE !== 1'b1 || ALUSrcE !== 1'b1 || ALUControlE !== 3'b010) begin
      errors++;
      $display("FAIL load_e: ResultSrcE0=%b RegWriteE=%b ALUSrcE=%b ALUControlE=%b required 1 1 1 010",
               ResultSrcE0, RegWriteE, ALUSrcE, ALUControlE);
    end
    bubble();
    checks++;
    if (RegWriteM !== 1'b1) begin
      errors++; $display("FAIL load_m: RegWriteM=%b required 1", RegWriteM);
    end
    bubble();
    bubble();
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (RegWriteE !== 1'b0 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || RegWriteW !== 1'b0 ||
        ResultSrcW !== 2'b00 || RetiredW !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: E=%b M=%b/%b W=%b/%b cnt=%0d required all 0",
               RegWriteE, RegWriteM, MemWriteM, RegWriteW, ResultSrcW, RetiredW);
    end
    apply_reset();
  endtask

  task automatic test_counter();
    apply_reset();
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, (i == 4 || i == 8));
    for (int i = 0; i < 4; i++) bubble();
    checks++;
    if (RetiredW !== 32'd10) begin
      errors++; $display("FAIL count10: RetiredW=%0d required 10", RetiredW);
    end
    apply_reset();
    for (int i = 0; i < 17; i++)
      cycle(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) bubble();
    checks++;
    if (w4_RetiredW !== 4'd1 || RetiredW !== 32'd17) begin
      errors++;
      $display("FAIL count_wrap: RetiredW4=%0d RetiredW32=%0d required 1 17", w4_RetiredW, RetiredW);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_retired = '0;
    apply_reset();
    test_reset();
    test_flush();
    test_branch_matrix();
    test_flush_branch();
    test_jump();
    test_load_use();
    test_reset_midop();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
